// File: rtl/pipe_add_pkg.sv
// rtl/pipe_add_pkg.sv - shared operation mode encoding for the pipelined adder
package pipe_add_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_SADD = 2'd2,
        MODE_ACC  = 2'd3
    } mode_t;

endpackage

// File: rtl/pipe_add_unit_if.sv
// rtl/pipe_add_unit_if.sv - operand/result handshake bundle for pipe_add_unit
interface pipe_add_unit_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [1:0]       mode;
    logic             acc_clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             overflow;

    modport master (
        output in_valid, in0, in1, mode, acc_clear, out_ready,
        input  in_ready, out_valid, out, overflow
    );

    modport slave (
        input  in_valid, in0, in1, mode, acc_clear, out_ready,
        output in_ready, out_valid, out, overflow
    );
endinterface

// File: rtl/add_core.sv
// rtl/add_core.sv - combinational add/sub/saturating-add/accumulate datapath
module add_core
    import pipe_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  mode_t            mode_i,
    input  logic [WIDTH-1:0] base_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] acc_sum;

    always_comb begin
        sum        = {1'b0, a_i} + {1'b0, b_i};
        diff       = {1'b0, a_i} - {1'b0, b_i};
        acc_sum    = {1'b0, base_i} + {1'b0, a_i};
        result_o   = sum[WIDTH-1:0];
        overflow_o = sum[WIDTH];
        case (mode_i)
            MODE_ADD: begin
                result_o   = sum[WIDTH-1:0];
                overflow_o = sum[WIDTH];
            end
            // The extra bit of the widened difference is set exactly when a < b.
            MODE_SUB: begin
                result_o   = diff[WIDTH-1:0];
                overflow_o = diff[WIDTH];
            end
            MODE_SADD: begin
                result_o   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                overflow_o = sum[WIDTH];
            end
            MODE_ACC: begin
                result_o   = acc_sum[WIDTH-1:0];
                overflow_o = acc_sum[WIDTH];
            end
            default: begin
                result_o   = sum[WIDTH-1:0];
                overflow_o = sum[WIDTH];
            end
        endcase
    end
endmodule

// File: rtl/pipe_add_unit.sv
// rtl/pipe_add_unit.sv - STAGES-deep valid/ready adder pipeline with accumulator
module pipe_add_unit
    import pipe_add_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic            clock,
    input  logic            reset,
    pipe_add_unit_if.slave  bus
);
    typedef struct packed {
        logic             valid;
        logic             ovf;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t           stage_q [STAGES];
    stage_t           stage_d [STAGES];
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] core_result;
    logic             core_overflow;
    logic             advance;
    logic             accept;
    mode_t            mode;

    assign mode     = mode_t'(bus.mode);
    assign advance  = !stage_q[STAGES-1].valid || bus.out_ready;
    assign accept   = bus.in_valid && advance;
    assign acc_base = bus.acc_clear ? '0 : acc_q;

    add_core #(
        .WIDTH(WIDTH)
    ) u_add_core (
        .a_i        (bus.in0),
        .b_i        (bus.in1),
        .mode_i     (mode),
        .base_i     (acc_base),
        .result_o   (core_result),
        .overflow_o (core_overflow)
    );

    // Data only moves behind a valid bit, so bubbles leave out/overflow at their last result.
    always_comb begin
        stage_d = stage_q;
        if (advance) begin
            stage_d[0].valid = bus.in_valid;
            if (bus.in_valid) begin
                stage_d[0].data = core_result;
                stage_d[0].ovf  = core_overflow;
            end
            for (int i = 1; i < STAGES; i++) begin
                stage_d[i].valid = stage_q[i-1].valid;
                if (stage_q[i-1].valid) begin
                    stage_d[i].data = stage_q[i-1].data;
                    stage_d[i].ovf  = stage_q[i-1].ovf;
                end
            end
        end
    end

    // Updated at acceptance rather than at the output so back-to-back ACC ops chain.
    always_comb begin
        acc_d = acc_q;
        if (accept && mode == MODE_ACC) begin
            acc_d = core_result;
        end else if (bus.acc_clear) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            acc_q <= '0;
        end else begin
            stage_q <= stage_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = stage_q[STAGES-1].valid;
    assign bus.out       = stage_q[STAGES-1].data;
    assign bus.overflow  = stage_q[STAGES-1].ovf;
endmodule

// File: tb/tb_pipe_add_unit.sv
// tb/tb_pipe_add_unit.sv - randomized scoreboard bench for pipe_add_unit (WIDTH=8, STAGES=3)
module tb_pipe_add_unit;
    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   m_acc;
    logic [8:0] exp_q [$];

    pipe_add_unit_if #(.WIDTH(8)) bus ();

    pipe_add_unit #(
        .WIDTH (8),
        .STAGES(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Reference: {overflow, result} per accepted op; acc follows the accumulator rules directly.
    function void model_step(input bit fire, input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] m, input bit clr);
        int s;
        logic [8:0] r;
        r = '0;
        if (fire) begin
            case (m)
                2'd0: begin s = int'(a) + int'(b); r = {s > 255, 8'(s % 256)}; end
                2'd1: begin s = int'(a) - int'(b) + 256; r = {a < b, 8'(s % 256)}; end
                2'd2: begin s = int'(a) + int'(b); r = (s > 255) ? 9'h1FF : {1'b0, 8'(s)}; end
                default: begin
                    s = (clr ? 0 : m_acc) + int'(a);
                    r = {s > 255, 8'(s % 256)};
                    m_acc = s % 256;
                end
            endcase
            exp_q.push_back(r);
        end
        if (!(fire && m == 2'd3) && clr) m_acc = 0;
    endfunction

    task automatic drive_cycle(input bit v, input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] m, input bit clr, input bit ordy,
                               output bit inf, output bit outf, output logic [7:0] o,
                               output logic ov, output logic ir, output logic ovld);
        bus.in_valid  = v;
        bus.in0       = a;
        bus.in1       = b;
        bus.mode      = m;
        bus.acc_clear = clr;
        bus.out_ready = ordy;
        #1;
        ir   = bus.in_ready;
        ovld = bus.out_valid;
        o    = bus.out;
        ov   = bus.overflow;
        inf  = v && (ir === 1'b1);
        outf = (ovld === 1'b1) && ordy;
        model_step(inf, a, b, m, clr);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.acc_clear = 1'b0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_acc = 0;
    endtask

    task automatic test_reset();
        bit inf, outf, got;
        logic [7:0] o;
        logic ov, ir, ovld;
        logic [8:0] e;
        do_reset();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out !== 8'd0) begin bad++; $display("FAIL reset_out got=%0d exp=0", bus.out); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        drive_cycle(1, 8'd50, 8'd0, 2'd3, 0, 1, inf, outf, o, ov, ir, ovld);
        drive_cycle(1, 8'd60, 8'd0, 2'd3, 0, 1, inf, outf, o, ov, ir, ovld);
        do_reset();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%b exp=0", bus.out_valid); end
        for (int i = 0; i < 6; i++) begin
            drive_cycle(0, 8'd0, 8'd0, 2'd0, 0, 1, inf, outf, o, ov, ir, ovld);
            total++; if (ovld !== 1'b0) begin bad++; $display("FAIL flushed_emerged cycle=%0d got=%b exp=0", i, ovld); end
        end
        drive_cycle(1, 8'd7, 8'd0, 2'd3, 0, 1, inf, outf, o, ov, ir, ovld);
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            drive_cycle(0, 8'd0, 8'd0, 2'd0, 0, 1, inf, outf, o, ov, ir, ovld);
            if (outf) begin
                got = 1;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                total++; if ({ov, o} !== 9'd7) begin bad++; $display("FAIL acc_after_reset got=%0d/%b exp=7/0", o, ov); end
            end
        end
        total++; if (!got) begin bad++; $display("FAIL acc_after_reset_timeout got=none exp=7"); end
    endtask

    task automatic test_modes();
        logic [7:0] a_t [3] = '{8'd200, 8'd5, 8'd200};
        logic [7:0] b_t [3] = '{8'd100, 8'd7, 8'd100};
        logic [1:0] m_t [3] = '{2'd0, 2'd1, 2'd2};
        logic [7:0] r_t [3] = '{8'd44, 8'd254, 8'd255};
        bit inf, outf;
        logic [7:0] o;
        logic ov, ir, ovld;
        logic [8:0] e;
        for (int w = 0; w < 8; w++) begin
            if (w < 3) drive_cycle(1, a_t[w], b_t[w], m_t[w], 0, 1, inf, outf, o, ov, ir, ovld);
            else       drive_cycle(0, 8'd0, 8'd0, 2'd0, 0, 1, inf, outf, o, ov, ir, ovld);
            if (w < 3) begin
                total++; if (!inf) begin bad++; $display("FAIL modes_accept w=%0d got=0 exp=1", w); end
            end
            total++;
            if (ovld !== (w >= 3 && w <= 5)) begin
                bad++; $display("FAIL modes_latency w=%0d got=%b exp=%b", w, ovld, (w >= 3 && w <= 5));
            end
            if (outf) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                if (w >= 3 && w <= 5) begin
                    total++;
                    if ({ov, o} !== {1'b1, r_t[w-3]}) begin
                        bad++; $display("FAIL modes_result w=%0d got=%0d/%b exp=%0d/1", w, o, ov, r_t[w-3]);
                    end
                end
            end
        end
    endtask

    task automatic test_acc_chain();
        logic [7:0] a_t [4] = '{8'd10, 8'd20, 8'd30, 8'd5};
        bit         c_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] r_t [4] = '{8'd10, 8'd30, 8'd60, 8'd5};
        bit inf, outf;
        logic [7:0] o;
        logic ov, ir, ovld;
        logic [8:0] e;
        int k;
        do_reset();
        k = 0;
        for (int w = 0; w < 10; w++) begin
            if (w < 4) drive_cycle(1, a_t[w], 8'hFF, 2'd3, c_t[w], 1, inf, outf, o, ov, ir, ovld);
            else       drive_cycle(0, 8'd0, 8'd0, 2'd0, 0, 1, inf, outf, o, ov, ir, ovld);
            if (outf) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                if (k < 4) begin
                    total++;
                    if ({ov, o} !== {1'b0, r_t[k]}) begin
                        bad++; $display("FAIL acc_chain k=%0d got=%0d/%b exp=%0d/0", k, o, ov, r_t[k]);
                    end
                end
                k++;
            end
        end
        total++; if (k != 4) begin bad++; $display("FAIL acc_chain_count got=%0d exp=4", k); end
    endtask

    task automatic test_stall();
        logic [7:0] a_t [4];
        logic [7:0] b_t [4];
        bit inf, outf;
        logic [7:0] o, first_o;
        logic ov, ir, ovld;
        logic [8:0] e;
        int k, n;
        for (int i = 0; i < 4; i++) begin
            a_t[i] = 8'($urandom);
            b_t[i] = 8'($urandom);
        end
        k = 0;
        first_o = 8'd0;
        for (int w = 0; w < 6; w++) begin
            drive_cycle(1, a_t[k], b_t[k], 2'd0, 0, 0, inf, outf, o, ov, ir, ovld);
            if (inf) k++;
            if (w == 3) first_o = o;
            if (w >= 3) begin
                total++; if (ir !== 1'b0) begin bad++; $display("FAIL stall_in_ready w=%0d got=%b exp=0", w, ir); end
                total++;
                if (exp_q.size() == 0 || o !== exp_q[0][7:0] || o !== first_o) begin
                    bad++; $display("FAIL stall_hold w=%0d got=%0d exp=%0d", w, o, first_o);
                end
            end
        end
        total++; if (k != 3) begin bad++; $display("FAIL stall_accept_count got=%0d exp=3", k); end
        n = 0;
        for (int w = 0; w < 20 && n < 4; w++) begin
            drive_cycle(k < 4, a_t[k % 4], b_t[k % 4], 2'd0, 0, 1, inf, outf, o, ov, ir, ovld);
            if (inf) k++;
            if (outf) begin
                n++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL stall_drain_extra got=%0d exp=none", o);
                end else begin
                    e = exp_q.pop_front();
                    if ({ov, o} !== e) begin bad++; $display("FAIL stall_drain n=%0d got=%0d/%b exp=%0d/%b", n, o, ov, e[7:0], e[8]); end
                end
            end
        end
        total++; if (n != 4 || exp_q.size() != 0) begin bad++; $display("FAIL stall_drain_count got=%0d exp=4", n); end
    endtask

    task automatic test_clear_while_stalled();
        bit inf, outf, got;
        logic [7:0] o;
        logic ov, ir, ovld;
        logic [8:0] e;
        drive_cycle(1, 8'd33, 8'd0, 2'd3, 0, 1, inf, outf, o, ov, ir, ovld);
        for (int w = 0; w < 8 && ir !== 1'b0; w++) begin
            drive_cycle(1, 8'd1, 8'd2, 2'd0, 0, 0, inf, outf, o, ov, ir, ovld);
        end
        drive_cycle(1, 8'd99, 8'd0, 2'd3, 1, 0, inf, outf, o, ov, ir, ovld);
        total++; if (inf) begin bad++; $display("FAIL clear_stall_accepted got=1 exp=0"); end
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
            drive_cycle(0, 8'd0, 8'd0, 2'd0, 0, 1, inf, outf, o, ov, ir, ovld);
            if (outf) begin
                e = exp_q.pop_front();
                total++; if ({ov, o} !== e) begin bad++; $display("FAIL clear_stall_drain got=%0d/%b exp=%0d/%b", o, ov, e[7:0], e[8]); end
            end
        end
        drive_cycle(1, 8'd7, 8'd0, 2'd3, 0, 1, inf, outf, o, ov, ir, ovld);
        got = 0;
        for (int w = 0; w < 8 && !got; w++) begin
            drive_cycle(0, 8'd0, 8'd0, 2'd0, 0, 1, inf, outf, o, ov, ir, ovld);
            if (outf) begin
                got = 1;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                total++; if ({ov, o} !== 9'd7) begin bad++; $display("FAIL clear_stall_acc got=%0d/%b exp=7/0", o, ov); end
            end
        end
        total++; if (!got) begin bad++; $display("FAIL clear_stall_timeout got=none exp=7"); end
    endtask

    task automatic test_random();
        bit inf, outf, v, clr, ordy, pstall;
        logic [7:0] o, po, a, b;
        logic [1:0] m;
        logic ov, pov, ir, ovld;
        logic [8:0] e;
        int acc_n, cyc;
        acc_n = 0; cyc = 0; pstall = 0; po = '0; pov = 1'b0;
        while (acc_n < 10000 && cyc < 60000) begin
            v    = 1'($urandom_range(0, 1));
            a    = 8'($urandom);
            b    = 8'($urandom);
            m    = 2'($urandom_range(0, 3));
            clr  = ($urandom_range(0, 7) == 0);
            ordy = 1'($urandom_range(0, 1));
            drive_cycle(v, a, b, m, clr, ordy, inf, outf, o, ov, ir, ovld);
            cyc++;
            if (inf) acc_n++;
            total++;
            if (ir !== (!ovld || ordy)) begin bad++; $display("FAIL rand_in_ready cyc=%0d got=%b out_valid=%b out_ready=%b", cyc, ir, ovld, ordy); end
            if (pstall) begin
                total++;
                if (ovld !== 1'b1 || o !== po || ov !== pov) begin
                    bad++; $display("FAIL rand_hold cyc=%0d got=%0d/%b exp=%0d/%b", cyc, o, ov, po, pov);
                end
            end
            pstall = (ovld === 1'b1) && !ordy;
            po = o; pov = ov;
            if (outf) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_extra cyc=%0d got=%0d exp=none", cyc, o);
                end else begin
                    e = exp_q.pop_front();
                    if ({ov, o} !== e) begin bad++; $display("FAIL rand_result cyc=%0d got=%0d/%b exp=%0d/%b", cyc, o, ov, e[7:0], e[8]); end
                end
            end
        end
        total++; if (acc_n != 10000) begin bad++; $display("FAIL rand_timeout got=%0d exp=10000", acc_n); end
        for (int w = 0; w < 12 && exp_q.size() > 0; w++) begin
            drive_cycle(0, 8'd0, 8'd0, 2'd0, 0, 1, inf, outf, o, ov, ir, ovld);
            if (outf) begin
                e = exp_q.pop_front();
                total++; if ({ov, o} !== e) begin bad++; $display("FAIL rand_drain got=%0d/%b exp=%0d/%b", o, ov, e[7:0], e[8]); end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_drain_left got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        total = 0;
        bad   = 0;
        m_acc = 0;
        bus.in_valid  = 1'b0;
        bus.in0       = '0;
        bus.in1       = '0;
        bus.mode      = '0;
        bus.acc_clear = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        test_reset();
        test_modes();
        test_acc_chain();
        test_stall();
        test_clear_while_stalled();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
